// File: rtl/shared_wr_port_arbiter.sv
`default_nettype none
// ============================================================================
// shared_wr_port_arbiter : round-robin arbiter funnelling NREQ lane-masked
// writers onto a 1W/1R memory. Optional same-address lane merge: SHARED_WR_MERGE_EN.
// Rev 1.0
// ============================================================================
module shared_wr_port_arbiter #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int LANE_W = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NREQ-1:0]                    req_valid,
  output logic [NREQ-1:0]                    req_ready,
  input  logic [NREQ*ADDR_W-1:0]             req_addr,
  input  logic [NREQ*DATA_W-1:0]             req_data,
  input  logic [NREQ*(DATA_W/LANE_W)-1:0]    req_be,
  input  logic [ADDR_W-1:0]                  rd_addr,
  output logic [DATA_W-1:0]                  rd_data,
  output logic [2:0]                         grant_id,
`ifdef SHARED_WR_MERGE_EN
  output logic                               merge_fire,
`endif
  output logic                               wr_fire
);

  localparam int NLANE = DATA_W / LANE_W;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NSLOT = 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [2:0]        r_last_grant;

  // Requesters unpacked into 8 slots so a 3-bit index always selects cleanly.
  logic [NSLOT-1:0]  w_valid;
  logic [ADDR_W-1:0] w_addr [NSLOT];
  logic [DATA_W-1:0] w_data [NSLOT];
  logic [NLANE-1:0]  w_be   [NSLOT];

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    if (i < NREQ) begin : g_live
      assign w_valid[i] = req_valid[i];
      assign w_addr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      assign w_data[i]  = req_data[i*DATA_W +: DATA_W];
      assign w_be[i]    = req_be[i*NLANE +: NLANE];
    end else begin : g_pad
      assign w_valid[i] = 1'b0;
      assign w_addr[i]  = '0;
      assign w_data[i]  = '0;
      assign w_be[i]    = '0;
    end
  end

  function automatic logic [2:0] wrap_add(input logic [2:0] base, input int off);
    logic [3:0] s;
    s = {1'b0, base} + 4'(off);
    if (s >= 4'(NREQ)) s = s - 4'(NREQ);
    return s[2:0];
  endfunction

  logic       w_any;
  logic [2:0] w_win;

  always_comb begin
    logic [2:0] idx;
    w_any = 1'b0;
    w_win = 3'd0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = wrap_add(r_last_grant, off);
      if (!w_any && w_valid[idx]) begin
        w_any = 1'b1;
        w_win = idx;
      end
    end
  end

`ifdef SHARED_WR_MERGE_EN
  logic       w_mrg;
  logic [2:0] w_mid;

  // Partner must follow the winner in rotation, share its address, and touch disjoint lanes.
  always_comb begin
    logic [2:0] idx;
    w_mrg = 1'b0;
    w_mid = 3'd0;
    for (int off = 1; off < NREQ; off++) begin
      idx = wrap_add(w_win, off);
      if (w_any && !w_mrg && w_valid[idx] && (w_addr[idx] == w_addr[w_win]) &&
          ((w_be[idx] & w_be[w_win]) == '0)) begin
        w_mrg = 1'b1;
        w_mid = idx;
      end
    end
  end
`endif

  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic [NLANE-1:0]  w_wr_be;

  always_comb begin
    w_wr_addr = w_addr[w_win];
    w_wr_data = w_data[w_win];
    w_wr_be   = w_be[w_win];
`ifdef SHARED_WR_MERGE_EN
    if (w_mrg) begin
      w_wr_be = w_be[w_win] | w_be[w_mid];
      for (int j = 0; j < NLANE; j++) begin
        if (w_be[w_mid][j]) w_wr_data[j*LANE_W +: LANE_W] = w_data[w_mid][j*LANE_W +: LANE_W];
      end
    end
`endif
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = rst_n && w_any && (w_win == 3'(i));
`ifdef SHARED_WR_MERGE_EN
      req_ready[i] = req_ready[i] || (rst_n && w_mrg && (w_mid == 3'(i)));
`endif
    end
  end

  assign wr_fire  = rst_n && w_any;
  assign grant_id = wr_fire ? w_win : 3'd0;
`ifdef SHARED_WR_MERGE_EN
  assign merge_fire = wr_fire && w_mrg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 3'(NREQ - 1);
    end else if (wr_fire) begin
      r_last_grant <= w_win;
    end
  end

  // Single masked write port; memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int j = 0; j < NLANE; j++) begin
        if (w_wr_be[j]) mem[w_wr_addr][j*LANE_W +: LANE_W] <= w_wr_data[j*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shared_wr_port_arbiter.sv
`default_nettype none
// tb_shared_wr_port_arbiter : directed scenarios plus random traffic, all scored
// against a word/lane-level memory model with a rotating-priority grant rule.
module tb_shared_wr_port_arbiter;
  localparam int NREQ = 3, ADDR_W = 4, DATA_W = 32, LANE_W = 8, NLANE = 4;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ*ADDR_W-1:0]   req_addr;
  logic [NREQ*DATA_W-1:0]   req_data;
  logic [NREQ*NLANE-1:0]    req_be;
  logic [ADDR_W-1:0]        rd_addr;
  logic [DATA_W-1:0]        rd_data;
  logic [2:0]               grant_id;
  logic                     wr_fire;
`ifdef SHARED_WR_MERGE_EN
  logic                     merge_fire;
`endif

  shared_wr_port_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANE_W(LANE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_be(req_be),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .grant_id(grant_id),
`ifdef SHARED_WR_MERGE_EN
    .merge_fire(merge_fire),
`endif
    .wr_fire(wr_fire)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0]     mmem   [16];
  bit              mknown [16][NLANE];
  int              last;
  logic [2:0]      obs_gid;
  logic [NREQ-1:0] obs_ready;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input int a, input logic [31:0] d, input logic [3:0] be);
    req_valid[i]                 = 1'b1;
    req_addr[i*ADDR_W +: ADDR_W] = 4'(a);
    req_data[i*DATA_W +: DATA_W] = d;
    req_be[i*NLANE +: NLANE]     = be;
  endtask

  // One clock: check grants at negedge, update the model, check read data after posedge.
  task automatic cycle();
    int k, m, ra, a, w;
    bit rk;
    logic [31:0] exp_rd;
    logic [NREQ-1:0] er;
    @(negedge clk);
    k = -1;
    m = -1;
    for (int off = 1; off <= NREQ; off++)
      if (k < 0 && req_valid[(last + off) % NREQ]) k = (last + off) % NREQ;
`ifdef SHARED_WR_MERGE_EN
    if (k >= 0)
      for (int off = 1; off < NREQ; off++) begin
        int c = (k + off) % NREQ;
        if (m < 0 && req_valid[c] && req_addr[c*ADDR_W +: ADDR_W] == req_addr[k*ADDR_W +: ADDR_W] &&
            (req_be[c*NLANE +: NLANE] & req_be[k*NLANE +: NLANE]) == 4'b0000) m = c;
      end
`endif
    er = '0;
    if (k >= 0) er[k] = 1'b1;
    if (m >= 0) er[m] = 1'b1;
    obs_ready = req_ready;
    obs_gid   = grant_id;
    chk("req_ready", req_ready, er);
    chk("wr_fire", wr_fire, k >= 0);
    chk("grant_id", grant_id, (k >= 0) ? k : 0);
`ifdef SHARED_WR_MERGE_EN
    chk("merge_fire", merge_fire, m >= 0);
`endif
    ra = rd_addr;
    exp_rd = mmem[ra];
    rk = 1'b1;
    for (int j = 0; j < NLANE; j++) rk = rk & mknown[ra][j];
    for (int p = 0; p < 2; p++) begin
      w = (p == 0) ? k : m;
      if (w >= 0) begin
        a = req_addr[w*ADDR_W +: ADDR_W];
        for (int j = 0; j < NLANE; j++)
          if (req_be[w*NLANE + j]) begin
            mmem[a][j*LANE_W +: LANE_W] = req_data[w*DATA_W + j*LANE_W +: LANE_W];
            mknown[a][j] = 1'b1;
          end
      end
    end
    if (k >= 0) last = k;
    @(posedge clk);
    #1;
    if (rk) chk("rd_data", rd_data, exp_rd);
    req_valid = req_valid & ~er;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_addr  = '0;
    req_data  = '0;
    req_be    = '0;
    rd_addr   = '0;
    last      = NREQ - 1;
    for (int a = 0; a < 16; a++)
      for (int j = 0; j < NLANE; j++) mknown[a][j] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_wr_fire", wr_fire, 0);
    chk("rst_rd_data", rd_data, 0);
    req_valid = '0;
    #2 rst_n = 1'b1;

    // All three collide on address 5
    set_req(0, 5, 32'h11111111, 4'hF);
    set_req(1, 5, 32'h22222222, 4'hF);
    set_req(2, 5, 32'h33333333, 4'hF);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t1_gid", obs_gid, i);
    end
    rd_addr = 5;
    cycle();
    chk("t1_mem5", rd_data, 32'h33333333);

    // Two continuous requesters alternate
    for (int i = 0; i < 6; i++) begin
      if (!req_valid[0]) set_req(0, 10, $urandom, 4'hF);
      if (!req_valid[2]) set_req(2, 11, $urandom, 4'hF);
      cycle();
      chk("t3_gid", obs_gid, (i % 2 == 0) ? 0 : 2);
      chk("t3_onehot", $countones(obs_ready), 1);
    end
    cycle();

    // Partial lane write
    set_req(1, 3, 32'h12345678, 4'hF);
    cycle();
    set_req(1, 3, 32'hAAAABBBB, 4'b0011);
    cycle();
    rd_addr = 3;
    cycle();
    chk("t2_mem3", rd_data, 32'h1234BBBB);

    // Read-first collision
    set_req(0, 7, 32'h00000000, 4'hF);
    cycle();
    set_req(0, 7, 32'hDEADBEEF, 4'hF);
    rd_addr = 7;
    cycle();
    chk("t4_rd_old", rd_data, 32'h00000000);
    cycle();
    chk("t4_rd_new", rd_data, 32'hDEADBEEF);

    // Empty byte-enable still consumes a grant
    set_req(0, 12, 32'hCAFEF00D, 4'hF);
    cycle();
    set_req(1, 12, 32'hFFFFFFFF, 4'b0000);
    set_req(2, 13, 32'h01020304, 4'hF);
    cycle();
    chk("t5_gid_be0", obs_gid, 1);
    cycle();
    chk("t5_gid_next", obs_gid, 2);
    rd_addr = 12;
    cycle();
    chk("t5_mem12", rd_data, 32'hCAFEF00D);

    // Asynchronous reset in the middle of a burst
    set_req(0, 1, 32'h0A0A0A0A, 4'hF);
    set_req(1, 2, 32'h0B0B0B0B, 4'hF);
    set_req(2, 4, 32'h0C0C0C0C, 4'hF);
    cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_ready", req_ready, 0);
    chk("t6_wr_fire", wr_fire, 0);
    chk("t6_rd_data", rd_data, 0);
    last = NREQ - 1;
    @(posedge clk);
    #1;
    chk("t6_rd_hold", rd_data, 0);
    set_req(0, 6, 32'h0D0D0D0D, 4'hF);
    #1 rst_n = 1'b1;
    cycle();
    chk("t6_gid_after", obs_gid, 0);
    repeat (3) cycle();

`ifdef SHARED_WR_MERGE_EN
    set_req(0, 9, 32'h00001234, 4'b0011);
    set_req(1, 9, 32'h56780000, 4'b1100);
    cycle();
    chk("t7_ready", obs_ready, 3'b011);
    rd_addr = 9;
    cycle();
    chk("t7_mem9", rd_data, 32'h56781234);
`endif

    // Random traffic; a narrow address window makes collisions and merges likely
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15)),
                  $urandom, 4'($urandom));
      rd_addr = 4'($urandom);
      cycle();
    end
    repeat (4) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shared_wr_port_arbiter.md
Name: shared_wr_port_arbiter

Overview:
- Owns a NREQ-requester to one-write-port memory. Each requester issues lane-masked (partial-width) writes over valid/ready.
- Round-robin arbitration grants at most one write per cycle to the single physical write port.
- Also provides one synchronous read port.
- Sits between independent producer blocks and a shared 16x32 register-file style memory, so the memory infers exactly 1 write port and 1 read port.

Parameters:
- NREQ, 3, number of write requesters (2..8)
- ADDR_W, 4, address width; memory depth = 2**ADDR_W
- DATA_W, 32, word width
- LANE_W, 8, lane width; DATA_W must be a multiple of LANE_W; NLANE = DATA_W/LANE_W

Ports:
- clk  in  1  clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester write request
- req_ready  out  NREQ  per-requester grant/accept (combinational)
- req_addr  in  NREQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  NREQ*DATA_W  packed write data
- req_be  in  NREQ*NLANE  packed lane enables, bit j covers lane [j*LANE_W +: LANE_W]
- rd_addr  in  ADDR_W  read address, sampled every cycle
- rd_data  out  DATA_W  registered read data
- grant_id  out  3  index of the requester written this cycle (valid when wr_fire)
- wr_fire  out  1  a write handshake occurred this cycle

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - rd_data = 0.
  - Round-robin pointer last_grant = NREQ-1, so requester 0 has first priority after reset.
  - Memory contents are not reset.
- Arbitration (combinational, per cycle):
  - Search req_valid starting at (last_grant+1) mod NREQ, wrapping.
  - The first asserted requester k wins: req_ready[k]=1, all other req_ready bits 0.
  - If no req_valid is set, req_ready=0 and wr_fire=0.
- Handshake: a write is accepted when req_valid[k]&req_ready[k].
  - At that posedge, each lane j with req_be[k][j]=1 is written into mem[req_addr[k]]; lanes with be=0 keep their old value.
  - last_grant <= k.
  - Requesters must hold valid, addr, data and be stable until ready. Losers simply wait; they are not dropped.
- Fairness:
  - A continuously requesting set is served in strict rotation.
  - Worst-case wait for any requester is NREQ-1 cycles.
- be == 0: the request is still granted and consumed, the pointer still advances, and the memory is unchanged.
- Read port:
  - rd_data <= mem[rd_addr] every posedge; 1-cycle latency.
  - Read-first semantics: if rd_addr equals the address written in the same cycle, rd_data returns the pre-write word. The new value is visible one cycle later.
- grant_id = k and wr_fire = 1 combinationally during the handshake cycle; otherwise grant_id = 0 and wr_fire = 0.
- Reset mid-operation: in-flight requests are not granted while rst_n=0 (req_ready forced 0), and the pointer returns to NREQ-1. Memory retains its contents.
- Synthesis requirement: exactly one memory write port and one read port are inferred. Lane writes are a single masked write, not per-requester ports.

Optional Feature:
- Macro: SHARED_WR_MERGE_EN.
- Defined:
  - After the primary winner k is chosen, a second requester m may also be granted in the same cycle. m is the next in rotation order after k with req_valid[m], req_addr[m]==req_addr[k], and (req_be[m] & req_be[k])==0.
  - Both get ready. Lanes are combined into one masked write: each lane takes data from whichever requester enables it.
  - last_grant <= k (not m).
  - grant_id reports k; added output merge_fire=1 in a merged cycle.
- Undefined: one grant per cycle only; merge_fire is not present.

Test Plan:
- Reset, then all three write addr 5 simultaneously with be=4'b1111, data 0x11111111/0x22222222/0x33333333. Required: grants in cycles 0,1,2 to req 0,1,2; mem[5]=0x33333333.
- Req1 alone writes addr 3 be=4'b0011 data 0xAAAA_BBBB over prior 0x12345678. Required: reading addr 3 gives 0x1234BBBB.
- Req0 and req2 held valid continuously for 6 cycles. Required: grant_id sequence 0,2,0,2,0,2; no req_ready overlap.
- Same-cycle write addr 7 = 0xDEADBEEF while rd_addr=7 holds old 0x0. Required: next rd_data = 0x0, the following cycle 0xDEADBEEF.
- be=0 request from req1, with req2 also valid. Required: req1 granted first, mem unchanged, req2 granted next cycle.
- Assert rst_n=0 asynchronously mid-burst. Required: req_ready=0 immediately, rd_data=0; after release req0 has priority.
- (SHARED_WR_MERGE_EN) req0 addr 9 be=0011 data 0x0000_1234, req1 addr 9 be=1100 data 0x5678_0000. Required: both ready in one cycle, merge_fire=1, mem[9]=0x56781234.
